// File: rtl/fta_master_arbiter.sv
// Round-robin arbiter sharing one FTA master port among NREQ requesters, with per-requester
// load tracking by TID and retry/timeout-to-error conversion. Optional: `FTA_ARB_PRIO0_EN.
module fta_master_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIDW    = 13,
    parameter int unsigned RETRIES = 300,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ-1:0]          req_we_i,
    input  logic [NREQ*TIDW-1:0]     req_tid_i,
    input  logic                     fta_stall_i,
    input  logic                     fta_ack_i,
    input  logic                     fta_rty_i,
    input  logic [TIDW-1:0]          fta_tid_i,
    output logic                     fta_cyc_o,
    output logic [$clog2(NREQ)-1:0]  sel_o,
    output logic [NREQ-1:0]          gnt_o,
    output logic [NREQ-1:0]          ack_o,
    output logic [NREQ-1:0]          rty_o,
    output logic [NREQ-1:0]          err_o,
    output logic                     stray_o
);
    localparam int unsigned SELW = $clog2(NREQ);
    localparam int unsigned CNTW = 10;
    localparam logic [CNTW-1:0] RTY_LAST = CNTW'(RETRIES - 1);
    localparam logic [CNTW-1:0] TMO_LAST = CNTW'(TIMEOUT - 1);

    typedef enum logic {
        SLOT_IDLE = 1'b0,
        SLOT_PEND = 1'b1
    } slot_e;

    slot_e           slot_q   [NREQ];
    logic [TIDW-1:0] tid_hold [NREQ];
    logic [CNTW-1:0] rty_cnt  [NREQ];
    logic [CNTW-1:0] tmo_cnt  [NREQ];
    logic [SELW-1:0] rr_ptr;

    logic [NREQ-1:0] outstanding;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] hit_oh;
    logic            resp;
    logic            hit;
    logic            grant_vld;
    logic            rr_upd;
    logic            grant_we;
    logic [SELW-1:0] grant_idx;
    logic [TIDW-1:0] grant_tid;
    logic [31:0]     cand;

    always_comb begin
        outstanding = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            outstanding[i] = (slot_q[i] == SLOT_PEND);
        end
    end

    assign eligible = req_i & ~outstanding;
    assign resp     = fta_ack_i | fta_rty_i;

    // Lowest pending slot whose held TID matches the response owns it.
    always_comb begin
        hit_oh = '0;
        hit    = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!hit && resp && outstanding[i] && (fta_tid_i == tid_hold[i])) begin
                hit_oh[i] = 1'b1;
                hit       = 1'b1;
            end
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        rr_upd    = 1'b0;
        cand      = '0;
        if (!fta_stall_i) begin
`ifdef FTA_ARB_PRIO0_EN
            // Requester 0 bypasses the rotation and leaves rr_ptr untouched.
            if (eligible[0]) begin
                grant_vld = 1'b1;
            end
`endif
            for (int unsigned k = 1; k <= NREQ; k++) begin
                cand = (32'(rr_ptr) + k) % NREQ;
                if (!grant_vld && eligible[SELW'(cand)]) begin
                    grant_vld = 1'b1;
                    grant_idx = SELW'(cand);
                    rr_upd    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_we  = 1'b0;
        grant_tid = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_idx == SELW'(i)) begin
                grant_we  = req_we_i[i];
                grant_tid = req_tid_i[i*TIDW +: TIDW];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                slot_q[i]   <= SLOT_IDLE;
                tid_hold[i] <= '0;
                rty_cnt[i]  <= '0;
                tmo_cnt[i]  <= '0;
            end
            rr_ptr    <= SELW'(NREQ - 1);
            fta_cyc_o <= 1'b0;
            sel_o     <= '0;
            gnt_o     <= '0;
            ack_o     <= '0;
            rty_o     <= '0;
            err_o     <= '0;
            stray_o   <= 1'b0;
        end else begin
            fta_cyc_o <= grant_vld;
            gnt_o     <= '0;
            ack_o     <= '0;
            rty_o     <= '0;
            err_o     <= '0;
            stray_o   <= resp & ~hit;
            if (grant_vld) begin
                sel_o <= grant_idx;
                if (rr_upd) begin
                    rr_ptr <= grant_idx;
                end
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (grant_vld && (grant_idx == SELW'(i))) begin
                    gnt_o[i] <= 1'b1;
                end
                if (slot_q[i] == SLOT_IDLE) begin
                    if (grant_vld && (grant_idx == SELW'(i)) && !grant_we) begin
                        slot_q[i]   <= SLOT_PEND;
                        tid_hold[i] <= grant_tid;
                        tmo_cnt[i]  <= '0;
                    end else if (!req_i[i]) begin
                        rty_cnt[i] <= '0;
                    end
                end else if (hit_oh[i]) begin
                    // A matched response always beats a timeout in the same cycle.
                    slot_q[i] <= SLOT_IDLE;
                    if (fta_ack_i) begin
                        ack_o[i]   <= 1'b1;
                        rty_cnt[i] <= '0;
                    end else if (rty_cnt[i] >= RTY_LAST) begin
                        err_o[i]   <= 1'b1;
                        rty_cnt[i] <= '0;
                    end else begin
                        rty_o[i]   <= 1'b1;
                        rty_cnt[i] <= rty_cnt[i] + 1'b1;
                    end
                end else if (tmo_cnt[i] == TMO_LAST) begin
                    slot_q[i]  <= SLOT_IDLE;
                    err_o[i]   <= 1'b1;
                    tmo_cnt[i] <= '0;
                end else if (tmo_cnt[i] != '1) begin
                    tmo_cnt[i] <= tmo_cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fta_master_arbiter.sv
// Scoreboard bench for fta_master_arbiter: expected output pulses are queued by edge number
// as stimulus is driven and compared against the DUT on every falling edge.
module tb_fta_master_arbiter;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned TIDW    = 13;
    localparam int unsigned RETRIES = 3;
    localparam int unsigned TIMEOUT = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_we;
    logic [NREQ*TIDW-1:0] req_tid;
    logic                 stall;
    logic                 f_ack;
    logic                 f_rty;
    logic [TIDW-1:0]      f_tid;
    logic                 fta_cyc;
    logic [1:0]           sel;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      rty;
    logic [NREQ-1:0]      err;
    logic                 stray;

    typedef struct {
        int         cyc;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic [3:0] ack;
        logic [3:0] rty;
        logic [3:0] err;
        logic       stray;
    } exp_t;

    exp_t sbq[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    int   seq[$];

    logic [3:0] m_g, m_a, m_r, m_e;
    logic [1:0] m_s;
    logic       m_st;

    fta_master_arbiter #(
        .NREQ(NREQ), .TIDW(TIDW), .RETRIES(RETRIES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .req_we_i(req_we), .req_tid_i(req_tid),
        .fta_stall_i(stall), .fta_ack_i(f_ack), .fta_rty_i(f_rty), .fta_tid_i(f_tid),
        .fta_cyc_o(fta_cyc), .sel_o(sel), .gnt_o(gnt), .ack_o(ack), .rty_o(rty),
        .err_o(err), .stray_o(stray)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic expect_ev(input int at, input logic [3:0] g, input logic [1:0] s,
                             input logic [3:0] a, input logic [3:0] r, input logic [3:0] e,
                             input logic st);
        exp_t x;
        int   pos;
        x.cyc = at; x.gnt = g; x.sel = s; x.ack = a; x.rty = r; x.err = e; x.stray = st;
        pos = sbq.size();
        while (pos > 0 && sbq[pos-1].cyc > at) pos--;
        sbq.insert(pos, x);
    endtask

    task automatic exp_gnt(input int at, input int i);
        expect_ev(at, 4'(1 << i), 2'(i), '0, '0, '0, 1'b0);
    endtask
    task automatic exp_ack(input int at, input int i);
        expect_ev(at, '0, '0, 4'(1 << i), '0, '0, 1'b0);
    endtask
    task automatic exp_rty(input int at, input int i);
        expect_ev(at, '0, '0, '0, 4'(1 << i), '0, 1'b0);
    endtask
    task automatic exp_err(input int at, input int i);
        expect_ev(at, '0, '0, '0, '0, 4'(1 << i), 1'b0);
    endtask
    task automatic exp_stray(input int at);
        expect_ev(at, '0, '0, '0, '0, '0, 1'b1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic we, input logic [TIDW-1:0] t);
        req[i]                = v;
        req_we[i]             = we;
        req_tid[i*TIDW +: TIDW] = t;
    endtask

    task automatic respond(input logic a, input logic r, input logic [TIDW-1:0] t);
        f_ack = a;
        f_rty = r;
        f_tid = t;
        tick();
        f_ack = 1'b0;
        f_rty = 1'b0;
    endtask

    function automatic logic [TIDW-1:0] tid_of(input int core, input int ch);
        return {6'(core), 3'd0, 4'(ch)};
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            m_g = '0; m_a = '0; m_r = '0; m_e = '0; m_s = '0; m_st = 1'b0;
            while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                if (sbq[0].cyc < cyc) begin
                    check("sb_late", 32'(sbq[0].cyc), 32'(cyc));
                end else begin
                    m_g  = m_g | sbq[0].gnt;
                    m_a  = m_a | sbq[0].ack;
                    m_r  = m_r | sbq[0].rty;
                    m_e  = m_e | sbq[0].err;
                    m_st = m_st | sbq[0].stray;
                    if (sbq[0].gnt != '0) m_s = sbq[0].sel;
                end
                void'(sbq.pop_front());
            end
            check("gnt", 32'(gnt), 32'(m_g));
            check("fta_cyc", 32'(fta_cyc), 32'(|m_g));
            if (m_g != '0) check("sel", 32'(sel), 32'(m_s));
            check("ack", 32'(ack), 32'(m_a));
            check("rty", 32'(rty), 32'(m_r));
            check("err", 32'(err), 32'(m_e));
            check("stray", 32'(stray), 32'(m_st));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of stimulus, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req = '0; req_we = '0; req_tid = '0;
        stall = 1'b0; f_ack = 1'b0; f_rty = 1'b0; f_tid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_cyc", 32'(fta_cyc), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rty", 32'(rty), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_stray", 32'(stray), 32'd0);
        tick();
        rst    = 1'b0;
        mon_en = 1'b1;

        // Four loads at once: rotation 0..3, then in-order acks and one unowned ack.
        for (int i = 0; i < 4; i++) begin
            set_req(i, 1'b1, 1'b0, tid_of(5, i + 1));
            exp_gnt(cyc + 1 + i, i);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            req[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            exp_ack(cyc + 1, i);
            respond(1'b1, 1'b0, tid_of(5, i + 1));
        end
        exp_stray(cyc + 1);
        respond(1'b1, 1'b0, 13'h1fff);

        // Requester 2 load, ack five cycles after grant, store reissued one edge after ack_o.
        set_req(2, 1'b1, 1'b0, 13'h0412);
        exp_gnt(cyc + 1, 2);
        tick();
        req[2] = 1'b0;
        repeat (4) tick();
        exp_ack(cyc + 1, 2);
        set_req(2, 1'b1, 1'b1, 13'h0412);
        exp_gnt(cyc + 2, 2);
        respond(1'b1, 1'b0, 13'h0412);
        tick();
        req[2] = 1'b0;

        // Retry limit: two rty pulses, third retry becomes err.
        for (int k = 0; k < 3; k++) begin
            set_req(1, 1'b1, 1'b0, tid_of(7, 1));
            exp_gnt(cyc + 1, 1);
            tick();
            req[1] = 1'b0;
            if (k < 2) exp_rty(cyc + 1, 1);
            else       exp_err(cyc + 1, 1);
            respond(1'b0, 1'b1, tid_of(7, 1));
        end
        tick();

        // Timeout err 8 edges after grant, late ack is stray.
        set_req(3, 1'b1, 1'b0, tid_of(9, 3));
        exp_gnt(cyc + 1, 3);
        tick();
        req[3] = 1'b0;
        exp_err(cyc + 8, 3);
        repeat (10) tick();
        exp_stray(cyc + 1);
        respond(1'b1, 1'b0, tid_of(9, 3));

        // ack+rty arriving on the timeout edge: ack only.
        set_req(3, 1'b1, 1'b0, tid_of(9, 4));
        exp_gnt(cyc + 1, 3);
        tick();
        req[3] = 1'b0;
        repeat (7) tick();
        exp_ack(cyc + 1, 3);
        respond(1'b1, 1'b1, tid_of(9, 4));
        repeat (3) tick();

        // Stall holds off grants; rr_ptr=3 wraps to 0 once released.
        stall = 1'b1;
        set_req(0, 1'b1, 1'b1, '0);
        set_req(1, 1'b1, 1'b1, '0);
        repeat (4) tick();
        stall = 1'b0;
        exp_gnt(cyc + 1, 0);
        exp_gnt(cyc + 2, 1);
        tick();
        req[0] = 1'b0;
        tick();
        req[1] = 1'b0;
        tick();

        // Two slots holding the same TID: lowest index is answered first.
        set_req(1, 1'b1, 1'b0, 13'h0abc);
        set_req(3, 1'b1, 1'b0, 13'h0abc);
        exp_gnt(cyc + 1, 3);
        exp_gnt(cyc + 2, 1);
        tick();
        req[3] = 1'b0;
        tick();
        req[1] = 1'b0;
        exp_ack(cyc + 1, 1);
        respond(1'b1, 1'b0, 13'h0abc);
        exp_ack(cyc + 1, 3);
        respond(1'b1, 1'b0, 13'h0abc);

        // All four post stores, requester 0 keeps requesting for six edges.
`ifdef FTA_ARB_PRIO0_EN
        seq = '{0, 0, 0, 0, 0, 0, 2, 3, 1};
`else
        seq = '{2, 3, 0, 1, 0, 0};
`endif
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, '0);
        for (int k = 0; k < seq.size(); k++) exp_gnt(cyc + 1 + k, seq[k]);
        for (int k = 0; k < seq.size(); k++) begin
            tick();
            if (seq[k] != 0) req[seq[k]] = 1'b0;
            if (k == 5) req[0] = 1'b0;
        end
        repeat (2) tick();

        // Reset with a load pending: the later response is stray, rotation restarts at 0.
        set_req(2, 1'b1, 1'b0, tid_of(3, 2));
        exp_gnt(cyc + 1, 2);
        tick();
        req[2] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_stray(cyc + 1);
        respond(1'b1, 1'b0, tid_of(3, 2));
        set_req(0, 1'b1, 1'b1, '0);
        set_req(2, 1'b1, 1'b1, '0);
        exp_gnt(cyc + 1, 0);
        exp_gnt(cyc + 2, 2);
        tick();
        req[0] = 1'b0;
        tick();
        req[2] = 1'b0;
        repeat (3) tick();

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
